// File: rtl/axi4lite_slave_regs_pkg.sv
// Shared constants and FSM state types for the AXI4-Lite slave register bank.
// AXIL_SLV_ROREG_EN selects the read-only ID register at index 0.
package axi4lite_slave_regs_pkg;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [31:0] ID_VALUE    = 32'hA5A5_0001;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

endpackage

// File: rtl/axil_regbank.sv
// Word-indexed register array: one synchronous write port, one combinational read port.
// With AXIL_SLV_ROREG_EN, index 0 reads the constant ID and ignores writes.
module axil_regbank
    import axi4lite_slave_regs_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int IDX_W    = 2,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic              wr_allowed;

`ifdef AXIL_SLV_ROREG_EN
    assign wr_allowed = (wr_idx_i != '0);
    assign rd_data_o  = (rd_idx_i == '0) ? ID_VALUE : regs_q[rd_idx_i];
`else
    assign wr_allowed = 1'b1;
    assign rd_data_o  = regs_q[rd_idx_i];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: this bank is tiny and must read back zero after reset, so every
            // entry is a reset flop; a large RAM would be left unreset instead.
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en_i && wr_allowed) begin
            regs_q[wr_idx_i] <= wr_data_i;
        end
    end

endmodule

// File: rtl/axi4lite_slave_regs.sv
// AXI4-Lite slave register bank: independent write (AW+W -> B) and read (AR -> R) FSMs.
// Define AXIL_SLV_ROREG_EN to make register 0 a read-only ID that answers writes with SLVERR.
module axi4lite_slave_regs
    import axi4lite_slave_regs_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            reg_wr_pulse,
    output logic [C_S_AXI_ADDR_WIDTH-3:0]   reg_wr_idx
);

    localparam int IDX_W    = C_S_AXI_ADDR_WIDTH - 2;
    localparam int NUM_REGS = 2 ** IDX_W;

    w_state_e                        w_state_q, w_state_d;
    r_state_e                        r_state_q, r_state_d;
    logic                            init_q;
    logic                            awready_q, awready_d;
    logic                            bvalid_q, bvalid_d;
    logic [1:0]                      bresp_q, bresp_d;
    logic                            arready_q, arready_d;
    logic                            rvalid_q, rvalid_d;
    logic [C_S_AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                            wr_pulse_q, wr_pulse_d;
    logic [IDX_W-1:0]                wr_idx_q, wr_idx_d;

    logic [IDX_W-1:0]                aw_idx, ar_idx;
    logic                            w_hs, ar_hs, ro_hit, wr_en;
    logic [C_S_AXI_DATA_WIDTH-1:0]   rd_data;
    logic                            unused_ok;

    assign aw_idx = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign ar_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign w_hs   = awready_q && S_AXI_AWVALID && S_AXI_WVALID;
    assign ar_hs  = arready_q && S_AXI_ARVALID;
    assign wr_en  = w_hs && !ro_hit;

`ifdef AXIL_SLV_ROREG_EN
    assign ro_hit = (aw_idx == '0);
`else
    assign ro_hit = 1'b0;
`endif

    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    axil_regbank #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W),
        .DATA_W   (C_S_AXI_DATA_WIDTH)
    ) u_regbank (
        .clk       (S_AXI_ACLK),
        .rst_n     (S_AXI_ARESETN),
        .wr_en_i   (wr_en),
        .wr_idx_i  (aw_idx),
        .wr_data_i (S_AXI_WDATA),
        .rd_idx_i  (ar_idx),
        .rd_data_o (rd_data)
    );

    // AWREADY/WREADY share one flop so the two channels can only be accepted together.
    always_comb begin
        // NOTE: every output gets a default first, so no path through the case
        // leaves a variable unassigned and no latch is inferred.
        w_state_d  = w_state_q;
        awready_d  = 1'b0;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        wr_pulse_d = 1'b0;
        wr_idx_d   = wr_idx_q;
        case (w_state_q)
            W_IDLE: begin
                if (w_hs) begin
                    bvalid_d   = 1'b1;
                    bresp_d    = ro_hit ? RESP_SLVERR : RESP_OKAY;
                    wr_pulse_d = !ro_hit;
                    wr_idx_d   = aw_idx;
                    w_state_d  = W_RESP;
                end else if (init_q && !awready_q && S_AXI_AWVALID && S_AXI_WVALID) begin
                    awready_d = 1'b1;
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    bvalid_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        arready_d = 1'b0;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rvalid_d  = 1'b1;
                    rdata_d   = rd_data;
                    r_state_d = R_DATA;
                end else if (init_q && !arready_q && S_AXI_ARVALID) begin
                    arready_d = 1'b1;
                end
            end
            R_DATA: begin
                if (S_AXI_RREADY) begin
                    rvalid_d  = 1'b0;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // init_q keeps both READYs low through the first cycle after reset release.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            init_q     <= 1'b0;
            w_state_q  <= W_IDLE;
            r_state_q  <= R_IDLE;
            awready_q  <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            wr_pulse_q <= 1'b0;
            wr_idx_q   <= '0;
        end else begin
            // NOTE: state flops use non-blocking assignments so every flop samples
            // the pre-edge values regardless of statement order.
            init_q     <= 1'b1;
            w_state_q  <= w_state_d;
            r_state_q  <= r_state_d;
            awready_q  <= awready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            wr_pulse_q <= wr_pulse_d;
            wr_idx_q   <= wr_idx_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = awready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = RESP_OKAY;
    assign reg_wr_pulse  = wr_pulse_q;
    assign reg_wr_idx    = wr_idx_q;

endmodule

// File: tb/tb_axi4lite_slave_regs.sv
// Scoreboard bench for axi4lite_slave_regs; define AXIL_SLV_ROREG_EN to cover the ID register build.
module tb_axi4lite_slave_regs;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  S_AXI_AWADDR, S_AXI_ARADDR;
    logic [2:0]  S_AXI_AWPROT, S_AXI_ARPROT;
    logic        S_AXI_AWVALID, S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA, S_AXI_RDATA;
    logic        S_AXI_WVALID, S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
    logic        S_AXI_BVALID, S_AXI_BREADY;
    logic        S_AXI_ARVALID, S_AXI_ARREADY;
    logic        S_AXI_RVALID, S_AXI_RREADY;
    logic        reg_wr_pulse;
    logic [1:0]  reg_wr_idx;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [4];
    logic [1:0]  exp_bresp_q [$];
    logic [31:0] exp_rdata_q [$];
    logic [3:0]  pend_w_addr;
    logic [31:0] pend_w_data;

    always #5 clk = ~clk;

    axi4lite_slave_regs dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .reg_wr_pulse  (reg_wr_pulse),
        .reg_wr_idx    (reg_wr_idx)
    );

    function automatic bit is_ro(input int idx);
`ifdef AXIL_SLV_ROREG_EN
        return idx == 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model_rd(input int idx);
        if (is_ro(idx)) return 32'hA5A5_0001;
        return model[idx];
    endfunction

    task automatic wr_issue(input logic [3:0] addr, input logic [31:0] data);
        pend_w_addr   = addr;
        pend_w_data   = data;
        S_AXI_AWADDR  = addr;
        S_AXI_WDATA   = data;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        exp_bresp_q.push_back(is_ro(int'(addr[3:2])) ? 2'b10 : 2'b00);
    endtask

    task automatic wr_hs();
        int n = 0;
        int idx = int'(pend_w_addr[3:2]);
        while (S_AXI_AWREADY !== 1'b1 && n < 20) begin
            checks++;
            if (S_AXI_WREADY !== 1'b0) begin
                errors++;
                $display("FAIL wready_alone: WREADY=%b while AWREADY=%b", S_AXI_WREADY, S_AXI_AWREADY);
            end
            @(posedge clk); #1;
            n++;
        end
        if (S_AXI_AWREADY !== 1'b1) begin
            checks++; errors++;
            $display("FAIL aw_timeout: AWREADY=%b after %0d cycles, want 1", S_AXI_AWREADY, n);
            S_AXI_AWVALID = 1'b0;
            S_AXI_WVALID  = 1'b0;
            return;
        end
        checks++;
        if (S_AXI_WREADY !== 1'b1) begin
            errors++;
            $display("FAIL wready_pair: WREADY=%b with AWREADY=1, want 1", S_AXI_WREADY);
        end
        @(posedge clk); #1;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        if (!is_ro(idx)) model[idx] = pend_w_data;
        checks++;
        if ({S_AXI_AWREADY, S_AXI_WREADY} !== 2'b00) begin
            errors++;
            $display("FAIL ready_one_cycle: AWREADY/WREADY=%b%b, want 00", S_AXI_AWREADY, S_AXI_WREADY);
        end
        checks++;
        if (S_AXI_BVALID !== 1'b1) begin
            errors++;
            $display("FAIL bvalid_next: BVALID=%b, want 1", S_AXI_BVALID);
        end
        checks++;
        if (reg_wr_pulse !== !is_ro(idx)) begin
            errors++;
            $display("FAIL wr_pulse: reg_wr_pulse=%b, want %b", reg_wr_pulse, !is_ro(idx));
        end
        if (!is_ro(idx)) begin
            checks++;
            if (reg_wr_idx !== 2'(idx)) begin
                errors++;
                $display("FAIL wr_idx: reg_wr_idx=%0d, want %0d", reg_wr_idx, idx);
            end
        end
    endtask

    task automatic wr_resp(input int stall);
        logic [1:0] exp;
        if (exp_bresp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL b_scoreboard: no expected response queued");
            return;
        end
        exp = exp_bresp_q.pop_front();
        if (stall > 0) S_AXI_BREADY = 1'b0;
        for (int i = 0; i < stall; i++) begin
            checks++;
            if (S_AXI_BVALID !== 1'b1 || S_AXI_BRESP !== exp) begin
                errors++;
                $display("FAIL b_stable: BVALID=%b BRESP=%b, want 1 %b", S_AXI_BVALID, S_AXI_BRESP, exp);
            end
            checks++;
            if (S_AXI_AWREADY !== 1'b0) begin
                errors++;
                $display("FAIL aw_during_b: AWREADY=%b while BVALID pending, want 0", S_AXI_AWREADY);
            end
            @(posedge clk); #1;
        end
        S_AXI_BREADY = 1'b1;
        checks++;
        if (S_AXI_BVALID !== 1'b1 || S_AXI_BRESP !== exp) begin
            errors++;
            $display("FAIL bresp: BVALID=%b BRESP=%b, want 1 %b", S_AXI_BVALID, S_AXI_BRESP, exp);
        end
        @(posedge clk); #1;
        checks++;
        if (S_AXI_BVALID !== 1'b0 || reg_wr_pulse !== 1'b0) begin
            errors++;
            $display("FAIL b_done: BVALID=%b reg_wr_pulse=%b, want 0 0", S_AXI_BVALID, reg_wr_pulse);
        end
    endtask

    task automatic rd_issue(input logic [3:0] addr);
        S_AXI_ARADDR  = addr;
        S_AXI_ARVALID = 1'b1;
        exp_rdata_q.push_back(model_rd(int'(addr[3:2])));
    endtask

    task automatic rd_hs();
        int n = 0;
        while (S_AXI_ARREADY !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (S_AXI_ARREADY !== 1'b1) begin
            checks++; errors++;
            $display("FAIL ar_timeout: ARREADY=%b after %0d cycles, want 1", S_AXI_ARREADY, n);
            S_AXI_ARVALID = 1'b0;
            return;
        end
        @(posedge clk); #1;
        S_AXI_ARVALID = 1'b0;
        checks++;
        if (S_AXI_ARREADY !== 1'b0 || S_AXI_RVALID !== 1'b1) begin
            errors++;
            $display("FAIL ar_done: ARREADY=%b RVALID=%b, want 0 1", S_AXI_ARREADY, S_AXI_RVALID);
        end
    endtask

    task automatic rd_resp(input int stall);
        logic [31:0] exp;
        if (exp_rdata_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL r_scoreboard: no expected read data queued");
            return;
        end
        exp = exp_rdata_q.pop_front();
        if (stall > 0) S_AXI_RREADY = 1'b0;
        for (int i = 0; i < stall; i++) begin
            checks++;
            if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== exp) begin
                errors++;
                $display("FAIL r_stable: RVALID=%b RDATA=%h, want 1 %h", S_AXI_RVALID, S_AXI_RDATA, exp);
            end
            @(posedge clk); #1;
        end
        S_AXI_RREADY = 1'b1;
        checks++;
        if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== exp || S_AXI_RRESP !== 2'b00) begin
            errors++;
            $display("FAIL rdata: RVALID=%b RDATA=%h RRESP=%b, want 1 %h 00",
                     S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP, exp);
        end
        @(posedge clk); #1;
        checks++;
        if (S_AXI_RVALID !== 1'b0) begin
            errors++;
            $display("FAIL r_done: RVALID=%b, want 0", S_AXI_RVALID);
        end
    endtask

    task automatic read_check(input logic [3:0] addr, input int stall);
        rd_issue(addr);
        rd_hs();
        rd_resp(stall);
    endtask

    task automatic write_check(input logic [3:0] addr, input logic [31:0] data);
        wr_issue(addr, data);
        wr_hs();
        wr_resp(0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        S_AXI_AWPROT = 3'b010; S_AXI_ARPROT = 3'b101;
        S_AXI_AWADDR = '0; S_AXI_WDATA = '0; S_AXI_ARADDR = '0;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
        for (int i = 0; i < 4; i++) model[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        // Offer a write and a read while still in reset; neither may be accepted yet.
        wr_issue(4'h4, 32'hDEAD_BEEF);
        rd_issue(4'h0);
        @(posedge clk); #1;
        checks++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID, reg_wr_pulse} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: AWR=%b WR=%b ARR=%b BV=%b RV=%b PULSE=%b, want all 0",
                     S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID, reg_wr_pulse);
        end
        checks++;
        if (S_AXI_BRESP !== 2'b00 || S_AXI_RRESP !== 2'b00 || S_AXI_RDATA !== 32'h0 || reg_wr_idx !== 2'd0) begin
            errors++;
            $display("FAIL reset_data: BRESP=%b RRESP=%b RDATA=%h IDX=%0d, want 00 00 0 0",
                     S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA, reg_wr_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b000) begin
            errors++;
            $display("FAIL ready_first_cycle: AWR=%b WR=%b ARR=%b, want 000",
                     S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY);
        end
    endtask

    task automatic test_basic_write_read();
        fork
            begin wr_hs(); wr_resp(0); end
            begin rd_hs(); rd_resp(0); end
        join
        read_check(4'h4, 0);
    endtask

    task automatic test_aw_before_w();
        S_AXI_AWADDR  = 4'hD;
        S_AXI_AWVALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (S_AXI_AWREADY !== 1'b0 || S_AXI_WREADY !== 1'b0) begin
                errors++;
                $display("FAIL aw_alone: AWREADY=%b WREADY=%b with only AWVALID, want 0 0",
                         S_AXI_AWREADY, S_AXI_WREADY);
            end
        end
        wr_issue(4'hD, 32'hC0DE_0003);
        wr_hs();
        wr_resp(0);
        read_check(4'hC, 0);
    endtask

    task automatic test_bready_stall();
        wr_issue(4'hC, 32'h5555_AAAA);
        wr_hs();
        wr_issue(4'h4, 32'h0BAD_F00D);
        wr_resp(10);
        wr_hs();
        wr_resp(0);
        read_check(4'hC, 2);
        read_check(4'h4, 0);
    endtask

    task automatic test_back_to_back_simul();
        wr_issue(4'h8, 32'h1234_5678);
        rd_issue(4'h8);
        fork
            begin wr_hs(); wr_resp(0); end
            begin rd_hs(); rd_resp(0); end
        join
        read_check(4'h8, 0);
    endtask

    task automatic test_all_regs();
        for (int i = 0; i < 4; i++) begin
            write_check({2'(i), 2'(3 - i)}, 32'h3C00_0000 ^ (32'(i) * 32'h0101_0101));
        end
        for (int i = 0; i < 4; i++) begin
            read_check({2'(i), 2'(i)}, i % 2);
        end
    endtask

`ifdef AXIL_SLV_ROREG_EN
    task automatic test_roreg();
        write_check(4'h0, 32'hFFFF_FFFF);
        read_check(4'h0, 0);
    endtask
`endif

    task automatic test_reset_mid_read();
        rd_issue(4'h4);
        rd_hs();
        S_AXI_RREADY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== exp_rdata_q[0]) begin
                errors++;
                $display("FAIL r_hold: RVALID=%b RDATA=%h, want 1 %h", S_AXI_RVALID, S_AXI_RDATA, exp_rdata_q[0]);
            end
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({S_AXI_RVALID, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_AWREADY, reg_wr_pulse} !== 5'b0 ||
            S_AXI_RDATA !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: RV=%b BV=%b ARR=%b AWR=%b PULSE=%b RDATA=%h, want all 0",
                     S_AXI_RVALID, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_AWREADY, reg_wr_pulse, S_AXI_RDATA);
        end
        exp_rdata_q.delete();
        for (int i = 0; i < 4; i++) model[i] = '0;
        S_AXI_RREADY = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            read_check({2'(i), 2'b00}, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic_write_read();
        test_aw_before_w();
        test_bready_stall();
        test_back_to_back_simul();
        test_all_regs();
`ifdef AXIL_SLV_ROREG_EN
        test_roreg();
`endif
        test_reset_mid_read();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi4lite_slave_regs.md
# axi4lite_slave_regs

AXI4-Lite slave register bank sitting directly downstream of the team's AXI4-Lite master block: it accepts the master's write and read transactions and responds on B and R channels. It holds a small bank of 32-bit registers addressed by word, exports a one-cycle write strobe to local logic, and is the endpoint the master's write/read sequence targets in the integrated design.

## Interface
- C_S_AXI_DATA_WIDTH, 32: data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4: byte address width; NUM_REGS = 2**(C_S_AXI_ADDR_WIDTH-2) (default 4).

- S_AXI_ACLK  in  1  single clock, all logic rising-edge.
- S_AXI_ARESETN  in  1  reset, asynchronous assert, active-low.
- S_AXI_AWADDR  in  ADDR_WIDTH  write byte address.
- S_AXI_AWPROT  in  3  accepted, ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write address handshake.
- S_AXI_WDATA  in  DATA_WIDTH  write data (no strobes; full-word writes).
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write data handshake.
- S_AXI_BRESP  out  2  write response.
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write response handshake.
- S_AXI_ARADDR  in  ADDR_WIDTH  read byte address.
- S_AXI_ARPROT  in  3  accepted, ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read address handshake.
- S_AXI_RDATA  out  DATA_WIDTH  read data.
- S_AXI_RRESP  out  2  read response, always OKAY (2'b00).
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read data handshake.
- reg_wr_pulse  out  1  one-cycle pulse on each committed register write.
- reg_wr_idx  out  ADDR_WIDTH-2  index of register written, valid with pulse.

## Operation
- Register index = ADDR[ADDR_WIDTH-1:2]; ADDR[1:0] ignored. All indices map to a register.
- Write FSM states W_IDLE, W_RESP. In W_IDLE, AWREADY and WREADY both assert for exactly one cycle when AWVALID && WVALID are both high; never one without the other. AW alone or W alone waits (no buffering of a single channel).
- On that handshake edge: register committed, reg_wr_pulse/reg_wr_idx asserted next cycle for one cycle, BVALID set, go W_RESP.
- W_RESP: BVALID and BRESP held stable until BREADY; on BVALID&&BREADY return W_IDLE. No new write accepted while BVALID high.
- Read FSM states R_IDLE, R_DATA. In R_IDLE with ARVALID, ARREADY pulses one cycle; RDATA captured from register at that edge; RVALID set; go R_DATA. RDATA/RRESP held stable until RREADY; then R_IDLE.
- Read and write channels independent; both may handshake in the same cycle. Same-index read and write in same cycle: read returns pre-write value.

## Timing
- Reset values: AWREADY, WREADY, BVALID, ARREADY, RVALID, reg_wr_pulse = 0; BRESP, RRESP = 2'b00; RDATA = 0; reg_wr_idx = 0; all registers 0 (except as in Configuration).
- Write: AW+W valid in cycle N -> READY high in N (registered, so earliest N+1 relative to VALID rise) -> BVALID in cycle after handshake. Minimum 3 cycles per write with BREADY held high.
- Read: ARREADY one cycle after ARVALID rises, RVALID the cycle after handshake; minimum 3 cycles per read.
- Reset mid-transaction: all VALID/READY outputs drop asynchronously; pending responses discarded; registers return to reset values.
- READY outputs never asserted during reset or in the first cycle after deassertion.

## Configuration
- AXIL_SLV_ROREG_EN defined: register 0 is a read-only ID holding constant 32'hA5A5_0001; writes to index 0 do not change it, produce no reg_wr_pulse, and return BRESP = SLVERR (2'b10). Reads return the ID with OKAY.
- Not defined: register 0 is ordinary read/write, reset 0; BRESP always OKAY.

## Structure
- Shared package: RESP_OKAY/RESP_SLVERR constants, ID constant, FSM state encodings for write and read channels.
- Natural sub-module: axil_regbank (register array, write port with index/data/enable, combinational read port); handshake FSMs stay in the top.

## Test plan
- After reset, write 32'hDEAD_BEEF to 0x4 with BREADY high -> one AW/W handshake, BVALID next cycle BRESP=00, reg_wr_pulse with idx 1; read 0x4 -> RDATA 32'hDEAD_BEEF, RRESP 00.
- AWVALID asserted 5 cycles before WVALID -> AWREADY stays 0 until WVALID high, then AWREADY and WREADY pulse together once.
- BREADY held low 10 cycles after write -> BVALID/BRESP stable for 10 cycles; second AW/W offered meanwhile not accepted until B handshake completes.
- Simultaneous write 32'h1234_5678 to 0x8 (previous 32'h0) and read 0x8 in same cycle -> RDATA 0; subsequent read returns 32'h1234_5678.
- RREADY low for 4 cycles, then ARESETN pulsed low -> RVALID drops immediately, all registers read 0 afterward.
- With AXIL_SLV_ROREG_EN: write 32'hFFFF_FFFF to 0x0 -> BRESP 2'b10, no reg_wr_pulse; read 0x0 returns 32'hA5A5_0001.
